// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: generates PC / pipeline-register enables and
// bubble flushes for data-memory waits, taken branches, load-use hazards,
// HALT retirement and data-memory timeouts. Also counts PC stall cycles.
module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_req,
    input  logic        dmem_done,
    input  logic        branch_taken,
    input  logic        load_use,
    input  logic        halt_in,
    output logic        pc_en,
    output logic        en_if_id,
    output logic        en_id_ex,
    output logic        en_ex_mem,
    output logic        en_mem_wb,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        halted,
    output logic        err,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2,
        ERR      = 2'd3
    } state_t;

    // Last wait-counter value tolerated before declaring a timeout.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  waitCnt_q, waitCnt_d;
    logic [15:0] stallCnt_q, stallCnt_d;

    // Registered state, wait counter and stall counter; reset abandons everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            waitCnt_q  <= 8'd0;
            stallCnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    // Next-state and enable/flush decode; memory stall beats halt beats branch beats load-use.
    always_comb begin
        state_d     = state_q;
        waitCnt_d   = waitCnt_q;
        pc_en       = 1'b0;
        en_if_id    = 1'b0;
        en_id_ex    = 1'b0;
        en_ex_mem   = 1'b0;
        en_mem_wb   = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;

        case (state_q)
            RUN: begin
                if (dmem_req && !dmem_done) begin
                    state_d   = MEM_WAIT;
                    waitCnt_d = 8'd0;
                end else if (halt_in) begin
                    en_mem_wb = 1'b1;
                    state_d   = HALT;
                end else if (branch_taken) begin
                    pc_en       = 1'b1;
                    en_if_id    = 1'b1;
                    en_id_ex    = 1'b1;
                    en_ex_mem   = 1'b1;
                    en_mem_wb   = 1'b1;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (load_use) begin
                    en_id_ex    = 1'b1;
                    en_ex_mem   = 1'b1;
                    en_mem_wb   = 1'b1;
                    flush_id_ex = 1'b1;
                end else begin
                    pc_en     = 1'b1;
                    en_if_id  = 1'b1;
                    en_id_ex  = 1'b1;
                    en_ex_mem = 1'b1;
                    en_mem_wb = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_done) begin
                    pc_en     = 1'b1;
                    en_if_id  = 1'b1;
                    en_id_ex  = 1'b1;
                    en_ex_mem = 1'b1;
                    en_mem_wb = 1'b1;
                    waitCnt_d = 8'd0;
                    state_d   = RUN;
                end else if (waitCnt_q == WAIT_LAST) begin
                    waitCnt_d = 8'd0;
                    state_d   = ERR;
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (rst) begin
            pc_en       = 1'b0;
            en_if_id    = 1'b0;
            en_id_ex    = 1'b0;
            en_ex_mem   = 1'b0;
            en_mem_wb   = 1'b0;
            flush_if_id = 1'b0;
            flush_id_ex = 1'b0;
        end
    end

    // Saturating count of PC-stalled cycles while the pipeline is still live.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (!pc_en && (state_q == RUN || state_q == MEM_WAIT) && stallCnt_q != 16'hFFFF) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
    end

    // Status outputs straight from the registered state.
    always_comb begin
        halted    = (state_q == HALT);
        err       = (state_q == ERR);
        stall_cnt = stallCnt_q;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dmem_req = 1'b0;
    logic        dmem_done = 1'b0;
    logic        branch_taken = 1'b0;
    logic        load_use = 1'b0;
    logic        halt_in = 1'b0;
    logic        pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic        flush_if_id, flush_id_ex, halted, err;
    logic [15:0] stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state.
    bit mWait, mHalt, mErr;
    int mWaitLen, mStalls;

    logic [4:0] enVec;
    logic [1:0] flushVec;

    pipe_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .dmem_req(dmem_req), .dmem_done(dmem_done),
        .branch_taken(branch_taken), .load_use(load_use), .halt_in(halt_in),
        .pc_en(pc_en), .en_if_id(en_if_id), .en_id_ex(en_id_ex),
        .en_ex_mem(en_ex_mem), .en_mem_wb(en_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .halted(halted), .err(err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Collected views of the enable and flush outputs.
    always_comb begin
        enVec    = {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb};
        flushVec = {flush_if_id, flush_id_ex};
    end

    task automatic applyStimulus(input logic r, input logic req, input logic done,
                                 input logic br, input logic lu, input logic hlt);
        @(negedge clk);
        rst = r; dmem_req = req; dmem_done = done;
        branch_taken = br; load_use = lu; halt_in = hlt;
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 0, 0, 0);
    endtask

    // Expected outputs for the current cycle, from the model and current inputs.
    function automatic logic [24:0] expectedWord(input logic r, input logic req, input logic done,
                                                 input logic br, input logic lu, input logic hlt);
        logic [4:0] e;
        logic [1:0] f;
        e = 5'b00000;
        f = 2'b00;
        if (!r && !mHalt && !mErr) begin
            if (mWait)            e = done ? 5'b11111 : 5'b00000;
            else if (req && !done) e = 5'b00000;
            else if (hlt)          e = 5'b00001;
            else if (br)           begin e = 5'b11111; f = 2'b11; end
            else if (lu)           begin e = 5'b00111; f = 2'b01; end
            else                   e = 5'b11111;
        end
        return {e, f, logic'(mHalt), logic'(mErr), 16'(mStalls)};
    endfunction

    // Advance the model across the coming clock edge.
    task automatic modelAdvance(input logic r, input logic req, input logic done,
                                input logic hlt, input logic pcEnExp);
        if (r) begin
            mWait = 0; mHalt = 0; mErr = 0; mWaitLen = 0; mStalls = 0;
        end else if (!mHalt && !mErr) begin
            if (!pcEnExp && mStalls < 65535) mStalls++;
            if (mWait) begin
                if (done) begin
                    mWait = 0; mWaitLen = 0;
                end else begin
                    mWaitLen++;
                    if (mWaitLen == TIMEOUT) begin mWait = 0; mErr = 1; end
                end
            end else if (req && !done) begin
                mWait = 1; mWaitLen = 0;
            end else if (hlt) begin
                mHalt = 1;
            end
        end
    endtask

    task automatic test_reset();
        applyStimulus(1, 1, 0, 1, 1, 1);
        vectors++; if (enVec !== 5'b00000) begin miscompares++; $display("[TB] FAIL reset_en: got %b expected %b", enVec, 5'b00000); end
        vectors++; if (flushVec !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_flush: got %b expected %b", flushVec, 2'b00); end
        applyStimulus(0, 0, 0, 0, 0, 0);
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_halted: got %b expected 0", halted); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        vectors++; if (stall_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_stall: got %0d expected 0", stall_cnt); end
        vectors++; if (enVec !== 5'b11111) begin miscompares++; $display("[TB] FAIL reset_idle_en: got %b expected %b", enVec, 5'b11111); end
    endtask

    task automatic test_zero_wait();
        doReset();
        applyStimulus(0, 1, 1, 0, 0, 0);
        vectors++; if (enVec !== 5'b11111) begin miscompares++; $display("[TB] FAIL zw_en: got %b expected %b", enVec, 5'b11111); end
        vectors++; if (flushVec !== 2'b00) begin miscompares++; $display("[TB] FAIL zw_flush: got %b expected %b", flushVec, 2'b00); end
        applyStimulus(0, 0, 0, 0, 0, 0);
        vectors++; if (enVec !== 5'b11111) begin miscompares++; $display("[TB] FAIL zw_after_en: got %b expected %b", enVec, 5'b11111); end
        vectors++; if (stall_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL zw_stall: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_three_wait();
        doReset();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 1, 0, c[0], 1, 0);
            vectors++; if (enVec !== 5'b00000 || flushVec !== 2'b00) begin miscompares++; $display("[TB] FAIL tw_stall_c%0d: got en=%b fl=%b expected en=00000 fl=00", c, enVec, flushVec); end
        end
        applyStimulus(0, 1, 1, 1, 1, 0);
        vectors++; if (enVec !== 5'b11111 || flushVec !== 2'b00) begin miscompares++; $display("[TB] FAIL tw_done: got en=%b fl=%b expected en=11111 fl=00", enVec, flushVec); end
        applyStimulus(0, 0, 0, 0, 0, 0);
        vectors++; if (stall_cnt !== 16'd3) begin miscompares++; $display("[TB] FAIL tw_stall_cnt: got %0d expected 3", stall_cnt); end
        vectors++; if (enVec !== 5'b11111) begin miscompares++; $display("[TB] FAIL tw_run_en: got %b expected %b", enVec, 5'b11111); end
    endtask

    task automatic test_branch_load_use();
        doReset();
        applyStimulus(0, 0, 0, 1, 1, 0);
        vectors++; if (enVec !== 5'b11111) begin miscompares++; $display("[TB] FAIL br_en: got %b expected %b", enVec, 5'b11111); end
        vectors++; if (flushVec !== 2'b11) begin miscompares++; $display("[TB] FAIL br_flush: got %b expected %b", flushVec, 2'b11); end
        applyStimulus(0, 0, 0, 0, 1, 0);
        vectors++; if (enVec !== 5'b00111) begin miscompares++; $display("[TB] FAIL lu_en: got %b expected %b", enVec, 5'b00111); end
        vectors++; if (flushVec !== 2'b01) begin miscompares++; $display("[TB] FAIL lu_flush: got %b expected %b", flushVec, 2'b01); end
        applyStimulus(0, 0, 0, 0, 0, 0);
        vectors++; if (stall_cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL lu_stall_cnt: got %0d expected 1", stall_cnt); end
    endtask

    task automatic test_timeout();
        doReset();
        applyStimulus(0, 1, 0, 0, 0, 0);
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(0, 1, 0, 0, 0, 0);
            vectors++; if (err !== 1'b0 || enVec !== 5'b00000) begin miscompares++; $display("[TB] FAIL to_wait_c%0d: got err=%b en=%b expected err=0 en=00000", c, err, enVec); end
        end
        for (int c = 5; c <= 7; c++) begin
            applyStimulus(0, 1, c[0], c[1], 1, 0);
            vectors++; if (err !== 1'b1 || enVec !== 5'b00000 || flushVec !== 2'b00) begin miscompares++; $display("[TB] FAIL to_err_c%0d: got err=%b en=%b fl=%b expected err=1 en=00000 fl=00", c, err, enVec, flushVec); end
        end
        vectors++; if (stall_cnt !== 16'd5) begin miscompares++; $display("[TB] FAIL to_stall_cnt: got %0d expected 5", stall_cnt); end
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0);
        vectors++; if (err !== 1'b0 || stall_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL to_clear: got err=%b stall=%0d expected err=0 stall=0", err, stall_cnt); end
        // Completion on the last tolerated wait cycle must win over the timeout.
        applyStimulus(0, 1, 0, 0, 0, 0);
        for (int c = 1; c <= 3; c++) applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0);
        vectors++; if (enVec !== 5'b11111) begin miscompares++; $display("[TB] FAIL to_edge_done: got %b expected %b", enVec, 5'b11111); end
        applyStimulus(0, 0, 0, 0, 0, 0);
        vectors++; if (err !== 1'b0 || enVec !== 5'b11111) begin miscompares++; $display("[TB] FAIL to_edge_run: got err=%b en=%b expected err=0 en=11111", err, enVec); end
    endtask

    task automatic test_halt();
        doReset();
        applyStimulus(0, 0, 0, 1, 1, 1);
        vectors++; if (enVec !== 5'b00001 || flushVec !== 2'b00) begin miscompares++; $display("[TB] FAIL halt_retire: got en=%b fl=%b expected en=00001 fl=00", enVec, flushVec); end
        applyStimulus(0, 0, 0, 0, 0, 0);
        vectors++; if (halted !== 1'b1 || enVec !== 5'b00000) begin miscompares++; $display("[TB] FAIL halt_state: got halted=%b en=%b expected halted=1 en=00000", halted, enVec); end
        applyStimulus(0, 1, 1, 1, 0, 0);
        vectors++; if (enVec !== 5'b00000 || flushVec !== 2'b00) begin miscompares++; $display("[TB] FAIL halt_hold: got en=%b fl=%b expected en=00000 fl=00", enVec, flushVec); end
        vectors++; if (stall_cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL halt_stall_cnt: got %0d expected 1", stall_cnt); end
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0);
        vectors++; if (halted !== 1'b0 || stall_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL halt_clear: got halted=%b stall=%0d expected halted=0 stall=0", halted, stall_cnt); end
    endtask

    task automatic test_random();
        logic r, req, done, br, lu, hlt;
        logic [24:0] exp, got;
        for (int i = 0; i < 3000; i++) begin
            r    = (i == 0) || ($urandom_range(99) < 3);
            req  = $urandom_range(99) < 30;
            done = $urandom_range(99) < 45;
            br   = $urandom_range(99) < 20;
            lu   = $urandom_range(99) < 25;
            hlt  = $urandom_range(99) < 4;
            applyStimulus(r, req, done, br, lu, hlt);
            if (i > 0) begin
                exp = expectedWord(r, req, done, br, lu, hlt);
                got = {enVec, flushVec, halted, err, stall_cnt};
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL rand_cycle%0d: got en=%b fl=%b h=%b e=%b st=%0d expected en=%b fl=%b h=%b e=%b st=%0d",
                             i, got[24:20], got[19:18], got[17], got[16], got[15:0],
                             exp[24:20], exp[19:18], exp[17], exp[16], exp[15:0]);
                end
                modelAdvance(r, req, done, hlt, exp[24]);
            end else begin
                modelAdvance(1, 0, 0, 0, 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_three_wait();
        test_branch_load_use();
        test_timeout();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum data-memory wait cycles before the error state is entered (legal range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port dmem_req, input, 1 bit: the instruction in the MEM stage performs a load or store.
REQ-005 SHALL have port dmem_done, input, 1 bit: data memory completes the access this cycle.
REQ-006 SHALL have port branch_taken, input, 1 bit: the EX stage resolved a taken branch or jump.
REQ-007 SHALL have port load_use, input, 1 bit: the ID stage depends on a load that is currently in EX.
REQ-008 SHALL have port halt_in, input, 1 bit: a HALT instruction has reached the MEM stage.
REQ-009 SHALL have ports pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, output, 1 bit each: write enables for the PC and for each pipeline register.
REQ-010 SHALL have ports flush_if_id and flush_id_ex, output, 1 bit each: load a bubble (all control bits 0) into that register on the next edge.
REQ-011 SHALL have port halted, output, 1 bit: the pipeline is stopped by HALT.
REQ-012 SHALL have port err, output, 1 bit: a data-memory timeout occurred.
REQ-013 SHALL have port stall_cnt, output, 16 bits: count of cycles in which pc_en was 0.

Function
REQ-014 SHALL implement the states RUN, MEM_WAIT, HALT and ERR, held in registers.
REQ-015 SHALL drive all enable and flush outputs combinationally from the current state and the current inputs.
REQ-016 In RUN with dmem_req=1 and dmem_done=0, SHALL drive every enable to 0 and every flush to 0, and SHALL go to MEM_WAIT next cycle.
REQ-017 In RUN with dmem_req=1 and dmem_done=1, SHALL behave as if no memory event occurred (zero-wait access).
REQ-018 In RUN with no memory stall and branch_taken=1, SHALL drive pc_en and all enables to 1 with flush_if_id=1 and flush_id_ex=1; load_use is ignored that cycle.
REQ-019 In RUN with no memory stall, branch_taken=0 and load_use=1, SHALL drive pc_en=0, en_if_id=0, flush_id_ex=1, and en_id_ex=en_ex_mem=en_mem_wb=1.
REQ-020 In RUN with no event, SHALL drive all enables to 1 and all flushes to 0.
REQ-021 Priority SHALL be: memory stall, then branch_taken, then load_use.
REQ-022 In MEM_WAIT with dmem_done=0, SHALL drive all enables to 0 and increment an 8-bit wait counter.
REQ-023 In MEM_WAIT with dmem_done=1, SHALL drive all enables to 1 that same cycle, clear the wait counter, and return to RUN; branch_taken and load_use are ignored that cycle.
REQ-024 In MEM_WAIT, when the wait counter equals MEM_TIMEOUT-1 and dmem_done=0, SHALL go to ERR next cycle; if dmem_done=1 in that same cycle, completion wins.
REQ-025 In RUN with halt_in=1 and no memory stall, SHALL drive en_mem_wb=1 and all other enables 0 (the HALT instruction retires), and SHALL go to HALT next cycle.
REQ-026 halt_in SHALL take priority over branch_taken and load_use.
REQ-027 In HALT and in ERR, SHALL drive all enables and flushes to 0; halted=1 in HALT and err=1 in ERR; both states are left only by rst.
REQ-028 stall_cnt SHALL increment on each edge where pc_en was 0 and the state was not HALT or ERR, and SHALL saturate at 16'hFFFF.

Reset
REQ-029 While rst=1, SHALL drive all enables and flushes to 0.
REQ-030 On an edge with rst=1, SHALL set the state to RUN and clear the wait counter and stall_cnt to 0, so that halted=0 and err=0 from the next cycle.
REQ-031 A reset asserted in MEM_WAIT, HALT or ERR SHALL abandon the operation with no residual state.

Verification
REQ-032 Zero-wait access: dmem_req=1, dmem_done=1 in RUN -> all enables 1, state stays RUN, stall_cnt unchanged.
REQ-033 Three-cycle wait: dmem_req=1, then dmem_done=1 on the 4th cycle -> enables 0 for 3 cycles, 1 on the 4th, stall_cnt=3.
REQ-034 load_use=1 and branch_taken=1 together -> flush_if_id=1, flush_id_ex=1, pc_en=1; then load_use alone -> pc_en=0, flush_id_ex=1, stall_cnt +1.
REQ-035 MEM_TIMEOUT=4 with dmem_done held at 0 -> err=1 from the 5th cycle after the request, all enables 0, held until rst.
REQ-036 halt_in=1 -> en_mem_wb=1 for one cycle, then halted=1 and all enables 0; rst=1 -> halted=0 and stall_cnt=0.
